build_rect_corners: RTL
=======================

BUILD_RECT_CORNERS -- requirements
Module: build_rect_corners

Interface
REQ-001 SHALL have parameter SAMPLES, default 32, giving the number of bars; it SHALL be a power of two, at least 2.
REQ-002 SHALL have parameter XW, default 10, giving the coordinate width in bits.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request a rebuild; sampled only in IDLE.
REQ-006 left_x  input  XW  left edge of the bar graph, in pixels.
REQ-007 right_x  input  XW  right edge of the bar graph, in pixels.
REQ-008 rect_corners  output  XW x (SAMPLES+1)  committed corner table; entry i is the left x of bar i; entry SAMPLES is the right edge.
REQ-009 busy  output  1  high while in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a new table is committed.
REQ-011 err  output  1  one-cycle pulse when a start is rejected.
REQ-012 valid  output  1  high once any table has been committed; stays high until reset.

Function
REQ-013 SHALL implement a state machine with states IDLE, FILL and COMMIT.
REQ-014 IDLE with start=1 and right_x > left_x and (right_x-left_x) >= SAMPLES:
  - latch left_x and right_x;
  - step = (right_x-left_x) >> log2(SAMPLES), integer, truncated;
  - load accumulator = left_x and index = 0;
  - go to FILL.
REQ-015 IDLE with start=1 and right_x <= left_x, or (right_x-left_x) < SAMPLES:
  - pulse err for one cycle;
  - stay in IDLE;
  - leave rect_corners, valid and done unchanged.
REQ-016 FILL: one shadow entry SHALL be written per cycle.
  - index < SAMPLES: shadow[index] = accumulator; accumulator += step; index += 1.
  - index == SAMPLES: shadow[SAMPLES] = latched right_x; go to COMMIT.
REQ-017 COMMIT: copy the entire shadow table to rect_corners in one edge, set valid=1, pulse done, return to IDLE.
REQ-018 rect_corners SHALL change only on the COMMIT edge, so a downstream reader never sees a partial table.
REQ-019 Corners SHALL satisfy rect_corners[i] = left_x + i*step for i < SAMPLES; the last bar absorbs the truncation remainder.
REQ-020 Accumulator arithmetic SHALL be XW+1 bits wide; no result can exceed right_x, so no wrap-around is possible.
REQ-021 Latency: with start sampled on edge 0, done SHALL be high in the cycle after edge SAMPLES+2, and rect_corners SHALL update on that same edge.
REQ-022 start while busy=1 SHALL be ignored, with no queuing and no err.
REQ-023 A start in the cycle done is high SHALL be accepted, because the block is back in IDLE.
REQ-024 left_x and right_x changing during FILL SHALL have no effect; the latched values apply.
REQ-025 With right_x, left_x and SAMPLES held constant, identical start requests SHALL produce bit-identical tables.

Reset
REQ-026 reset_n=0 SHALL immediately force:
  - state IDLE;
  - busy=0, done=0, err=0, valid=0;
  - every rect_corners entry = 0;
  - shadow table, accumulator and index = 0.
REQ-027 Reset asserted mid-FILL or mid-COMMIT SHALL abort the build; no partial table is ever committed.
REQ-028 After reset_n rises, the block SHALL accept start on the first edge.

Verification
REQ-029 SAMPLES=32, left=0, right=640, start one cycle -> step 20; corners 0, 20, ..., 620, 640; done on edge 34; valid=1.
REQ-030 left=100, right=200 -> step 3; corners[0..31] = 100, 103, ..., 193; corners[32] = 200; one done pulse.
REQ-031 left=300, right=300, then left=10, right=41 -> err pulse each time; busy never rises; table and valid unchanged from the prior state.
REQ-032 start held high for 40 cycles with left=0, right=640 -> exactly one build while busy, then a second build starting on the edge after done.
REQ-033 reset_n dropped at FILL index 10 after a prior committed 0..640 table -> all outputs 0 immediately, valid=0; after release, a new build commits cleanly.
REQ-034 Change left_x and right_x every cycle during FILL -> committed table matches the values latched at start.

Source files
------------

// File: rtl/build_rect_corners.sv
// Builds the x-corner table for a SAMPLES-bar graph between left_x and right_x.
// Entries are filled into a shadow table one per cycle, then published in a single edge.
module build_rect_corners #(
    parameter int SAMPLES = 32,
    parameter int XW      = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [XW-1:0]               left_x,
    input  logic [XW-1:0]               right_x,
    output logic [SAMPLES:0][XW-1:0]    rect_corners,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        valid
);

    localparam int LOG2S = $clog2(SAMPLES);
    localparam int IW    = LOG2S + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES);
    localparam logic [XW:0]   MIN_SPAN = (XW+1)'(SAMPLES);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t                     state;
    logic [SAMPLES:0][XW-1:0]   shadow;
    logic [XW:0]                acc;
    logic [XW-1:0]              step;
    logic [XW-1:0]              right_lat;
    logic [IW-1:0]              index;

    logic [XW-1:0] span;
    logic          start_ok;

    assign span     = right_x - left_x;
    assign start_ok = (right_x > left_x) && ({1'b0, span} >= MIN_SPAN);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shadow table is cleared on reset too, so an aborted build leaves no stale entries behind.
            state        <= IDLE;
            shadow       <= '0;
            rect_corners <= '0;
            acc          <= '0;
            step         <= '0;
            right_lat    <= '0;
            index        <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            valid        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            right_lat <= right_x;
                            step      <= span >> LOG2S;
                            acc       <= {1'b0, left_x};
                            index     <= '0;
                            state     <= FILL;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (index == LAST_IDX) begin
                        shadow[index] <= right_lat;
                        state         <= COMMIT;
                    end else begin
                        // The carry bit can never be set; clamping to the right edge keeps it harmless anyway.
                        shadow[index] <= acc[XW] ? right_lat : acc[XW-1:0];
                        acc           <= acc + {1'b0, step};
                        index         <= index + 1'b1;
                    end
                end
                COMMIT: begin
                    rect_corners <= shadow;
                    valid        <= 1'b1;
                    done         <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
